issue_select: RTL
=================

Name: issue_select

Overview:
- Downstream consumer of the compacting instruction queue.
- Each cycle it scans the queue's entries oldest-first (index 0 is oldest) and picks the oldest hazard-free entry.
- It pulses that entry's pop line and latches the entry into an output register for the execute stage.
- It owns the register scoreboard: set on issue, cleared on writeback.

Parameters:
- Size, 16, queue depth; must equal the queue's Size.
- RegCount, 32, architectural registers; register 0 is never busy.
- Width, $clog2(Size), localparam, index width.

Ports:
- clk_ni  input  1  clock; all state updates on its falling edge.
- rst_i  input  1  synchronous, active-high reset.
- size_i  input  Width+1  queue occupancy; entries at index >= size_i are invalid.
- entries_i  input  issue_entry_t[Size]  queue contents, unpacked array.
- pop_o  output  1[Size]  unpacked array, at most one bit set, combinational.
- issue_valid_o  output  1  output register holds an instruction.
- issue_o  output  issue_entry_t  issued instruction.
- exec_ready_i  input  1  execute stage accepts issue_o this edge.
- wb_valid_i  input  1  writeback strobe.
- wb_rd_i  input  $clog2(RegCount)  register being written back.
- busy_o  output  RegCount  scoreboard state.

Behaviour:
- Reset values: issue_valid_o=0, issue_o='0, busy_o='0. pop_o is all-zero while rst_i is high.
- Effective busy (combinational):
  - eff_busy = busy_o with bit wb_rd_i cleared when wb_valid_i is set.
  - A writeback therefore unblocks a consumer in the same cycle.
- An entry i is ready only if all of the following hold:
  - i < size_i.
  - uses_rs1 implies !eff_busy[rs1]; uses_rs2 likewise for rs2.
  - writes_rd implies !eff_busy[rd] (WAW against in-flight writers).
  - For every older valid entry j < i:
    - RAW: entry i's used sources do not match j's rd when j writes_rd.
    - WAR: entry i's rd does not match j's used sources when i writes_rd.
    - WAW: entry i's rd does not match j's rd when both write.
  - Register 0 never causes a hazard.
- Slot free: slot_free = !issue_valid_o || exec_ready_i.
- Selection: sel = lowest-index ready entry. Issue happens iff slot_free and some entry is ready.
- Issue cycle:
  - pop_o[sel]=1, all other bits 0.
  - On the edge: issue_o <= entries_i[sel], issue_valid_o <= 1.
  - If writes_rd and rd != 0: busy[rd] <= 1.
- No issue, drain only: if exec_ready_i && issue_valid_o, issue_valid_o <= 0 and issue_o holds its value.
- exec_ready_i with issue_valid_o=0 is ignored.
- Writeback: busy[wb_rd_i] <= 0. If the same edge also issues a writer of that register, the set wins.
- Writeback of a non-busy register or of register 0 has no effect.
- Throughput and latency:
  - At most one issue per cycle.
  - Latency is one edge from an entry becoming ready to issue_valid_o rising.
  - Back-to-back issue is sustained while exec_ready_i stays high.
- size_i=0: no pop, no issue.
- size_i=Size: all entries are considered.
- A reset asserted mid-stream drops the held instruction and clears the whole scoreboard on that edge.

Decomposition:
- Package weasel_pkg holds:
  - reg_idx_t (logic [$clog2(RegCount)-1:0]).
  - issue_entry_t struct: opcode, rd, rs1, rs2, uses_rs1, uses_rs2, writes_rd.
  - Constant RegCount.
- One sub-module, scoreboard:
  - Owns busy_o state, set/clear ports and set-wins priority.
  - Provides the combinational eff_busy view.
- Hazard matrix and priority select stay in issue_select.

Test Plan:
- Reset then size_i=0 for 5 cycles -> pop_o all 0, issue_valid_o=0, busy_o=0.
- Entry0 {rd=3, writes} and entry1 {rs1=3}, size_i=2, exec_ready_i=1:
  - Cycle 1: pop_o[0]=1, issue_o.rd=3; next edge busy_o[3]=1.
  - Entry1 (now at index 0) stays blocked until wb_valid_i=1, wb_rd_i=3.
  - It issues in that same cycle.
- Entry0 {rs1=5} with busy[5]=1, entry1 {rd=7, rs1=1} independent -> pop_o[1]=1, out-of-order issue; entry0 is retained.
- WAR check: entry0 {rs1=4} blocked by busy[5] via rs2=5, entry1 {rd=4} -> no issue until reg 5 clears; then entry0 issues first.
- exec_ready_i=0 with issue_valid_o=1 and ready entries -> pop_o=0 and issue_o stable for 3 cycles. Raising exec_ready_i gives issue on the next edge.
- Same-edge wb_rd_i=6 and issue of {rd=6, writes} -> busy_o[6]=1 after the edge.
- rst_i pulsed while issue_valid_o=1 and busy_o=0x0000_0108 -> both zero after the edge.

Source files
------------

// File: rtl/weasel_pkg.sv
// rtl/weasel_pkg.sv - shared register index, issue entry layout and hazard helper
package weasel_pkg;

  localparam int RegCount = 32;
  localparam int RegIdxW = $clog2(RegCount);

  typedef logic [RegIdxW-1:0] reg_idx_t;

  typedef struct packed {
    logic [6:0] opcode;
    reg_idx_t   rd;
    reg_idx_t   rs1;
    reg_idx_t   rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
  } issue_entry_t;

  // Register 0 is hardwired, so it never participates in a dependency.
  function automatic logic reg_clash(reg_idx_t a, reg_idx_t b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - register busy bits, set on issue and cleared on writeback
module scoreboard
  import weasel_pkg::*;
#(
  parameter int RegCount = weasel_pkg::RegCount
) (
  input  logic                clk_ni,
  input  logic                rst_i,
  input  logic                set_i,
  input  reg_idx_t            set_rd_i,
  input  logic                clr_i,
  input  reg_idx_t            clr_rd_i,
  output logic [RegCount-1:0] busy_o,
  output logic [RegCount-1:0] eff_busy_o
);

  // Writeback is visible to the hazard check in the cycle it arrives.
  always_comb begin
    eff_busy_o = busy_o;
    if (clr_i) eff_busy_o[clr_rd_i] = 1'b0;
  end

  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      busy_o <= '0;
    end else begin
      if (clr_i) busy_o[clr_rd_i] <= 1'b0;
      // A same-edge issue of a new writer must win over the old writer's writeback.
      if (set_i && set_rd_i != '0) busy_o[set_rd_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/issue_select.sv
// rtl/issue_select.sv - oldest-first hazard-free issue picker with output register
module issue_select
  import weasel_pkg::*;
#(
  parameter int Size = 16,
  parameter int RegCount = weasel_pkg::RegCount
) (
  input  logic                clk_ni,
  input  logic                rst_i,
  input  logic [$clog2(Size):0] size_i,
  input  issue_entry_t        entries_i [Size],
  output logic                pop_o [Size],
  output logic                issue_valid_o,
  output issue_entry_t        issue_o,
  input  logic                exec_ready_i,
  input  logic                wb_valid_i,
  input  reg_idx_t            wb_rd_i,
  output logic [RegCount-1:0] busy_o
);

  localparam int Width = $clog2(Size);

  logic [RegCount-1:0] eff_busy;
  logic [Size-1:0]     ready;
  logic [Width-1:0]    sel;
  logic                found;
  logic                slot_free;
  logic                do_issue;

  scoreboard #(.RegCount(RegCount)) u_scoreboard (
    .clk_ni    (clk_ni),
    .rst_i     (rst_i),
    .set_i     (do_issue && entries_i[sel].writes_rd),
    .set_rd_i  (entries_i[sel].rd),
    .clr_i     (wb_valid_i),
    .clr_rd_i  (wb_rd_i),
    .busy_o    (busy_o),
    .eff_busy_o(eff_busy)
  );

  // Every entry older than a valid entry is itself valid, so j < i needs no size check.
  always_comb begin
    ready = '0;
    for (int i = 0; i < Size; i++) begin
      ready[i] = (Width + 1)'(i) < size_i;
      if (entries_i[i].uses_rs1 && entries_i[i].rs1 != '0 && eff_busy[entries_i[i].rs1])
        ready[i] = 1'b0;
      if (entries_i[i].uses_rs2 && entries_i[i].rs2 != '0 && eff_busy[entries_i[i].rs2])
        ready[i] = 1'b0;
      if (entries_i[i].writes_rd && entries_i[i].rd != '0 && eff_busy[entries_i[i].rd])
        ready[i] = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (entries_i[j].writes_rd) begin
          if (entries_i[i].uses_rs1 && reg_clash(entries_i[i].rs1, entries_i[j].rd)) ready[i] = 1'b0;
          if (entries_i[i].uses_rs2 && reg_clash(entries_i[i].rs2, entries_i[j].rd)) ready[i] = 1'b0;
          if (entries_i[i].writes_rd && reg_clash(entries_i[i].rd, entries_i[j].rd)) ready[i] = 1'b0;
        end
        if (entries_i[i].writes_rd) begin
          if (entries_i[j].uses_rs1 && reg_clash(entries_i[i].rd, entries_i[j].rs1)) ready[i] = 1'b0;
          if (entries_i[j].uses_rs2 && reg_clash(entries_i[i].rd, entries_i[j].rs2)) ready[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = Size - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel   = Width'(i);
        found = 1'b1;
      end
    end
  end

  assign slot_free = !issue_valid_o || exec_ready_i;
  assign do_issue  = found && slot_free && !rst_i;

  always_comb begin
    for (int i = 0; i < Size; i++) pop_o[i] = do_issue && (sel == Width'(i));
  end

  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      issue_valid_o <= 1'b0;
      issue_o       <= '0;
    end else if (do_issue) begin
      issue_valid_o <= 1'b1;
      issue_o       <= entries_i[sel];
    end else if (exec_ready_i && issue_valid_o) begin
      issue_valid_o <= 1'b0;
    end
  end

endmodule
